axi_lite_master: RTL
====================

# axi_lite_master

Single-outstanding AXI4-Lite initiator that turns a simple command/response request port into AXI4-Lite write and read transactions. It is the initiator-side counterpart of the team's AXI4-Lite responder. It uses the same reduced channel set: no PROT, STRB, BRESP or RRESP. It sits between a local controller or test sequencer and any AXI4-Lite responder in the design.

## Interface
Parameters:
- TIMEOUT_CYCLES, 256: watchdog limit in cycles; only used when AXIL_MASTER_TIMEOUT_EN is defined.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  sole clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  request present
- cmd_ready  output  1  block can accept a request (high only in IDLE)
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  32  transaction address
- cmd_wdata  input  32  write data (ignored for reads)
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed
- rsp_rdata  output  32  read data; 0 for writes and errors
- rsp_err  output  1  transaction aborted by timeout
- awaddr  output  32, awvalid  output  1, awready  input  1
- wdata  output  32, wvalid  output  1, wready  input  1
- bvalid  input  1, bready  output  1
- araddr  output  32, arvalid  output  1, arready  input  1
- rdata  input  32, rvalid  input  1, rready  output  1

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP.
- **IDLE**
  - cmd_ready=1.
  - cmd_valid&&cmd_ready captures addr/wdata/write into registers.
  - Next state is WR_REQ if cmd_write, else RD_REQ.
- **WR_REQ**
  - awvalid and wvalid both assert, with awaddr=cmd_addr and wdata=cmd_wdata.
  - Each valid is held until its own handshake (valid&&ready at a rising edge), then dropped. Internal aw_done/w_done flags track this.
  - The two handshakes may occur in the same cycle or in either order.
  - When both are done, go to WR_RESP.
- **WR_RESP**
  - bready=1.
  - On bvalid, go to RESP with rsp_rdata=0 and rsp_err=0.
- **RD_REQ**
  - arvalid=1, araddr=cmd_addr, held until arready.
  - Then go to RD_RESP.
- **RD_RESP**
  - rready=1.
  - On rvalid, capture rdata into rsp_rdata with rsp_err=0, then go to RESP.
- **RESP**
  - rsp_valid=1; all AXI valids/readies are low.
  - On rsp_ready, go to IDLE.
- **Protocol rules**
  - AXI address/data outputs stay stable while their valid is high.
  - A valid never drops before its handshake, except on timeout or reset.
  - bready/rready are low outside WR_RESP/RD_RESP.
  - At most one transaction is outstanding at any time.
- **Reset** (asserted at any time, including mid-transaction)
  - All outputs go to 0 immediately: awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_err, rsp_rdata, awaddr, wdata and araddr are 0.
  - cmd_ready=0 while reset is asserted, then 1 from the first cycle after release.
  - State returns to IDLE and the aw/w done flags clear.

## Timing
- All outputs are registered or decoded directly from registered state; there are no combinational input-to-output paths.
- AXI valids rise the cycle after the cmd accept edge.
- rsp_valid rises the cycle after the final B or R handshake edge.
- cmd_ready returns the cycle after the rsp handshake; back-to-back commands lose one IDLE cycle.
- With the team's responder (one-cycle ready pulse), taking the cmd accept edge as N:
  - Write: rsp_valid high after edge N+3, for a 4-cycle command-to-response latency.
  - Read: same latency, rsp_valid high after edge N+3.

## Configuration
- Macro AXIL_MASTER_TIMEOUT_EN.
- **Defined**
  - A counter of ≥9 bits clears on entry to WR_REQ/RD_REQ and increments every cycle in WR_REQ, WR_RESP, RD_REQ or RD_RESP.
  - When it reaches TIMEOUT_CYCLES without completion, all AXI valids/readies drop on the next edge and the FSM goes to RESP with rsp_err=1 and rsp_rdata=0.
  - A handshake that arrives on the same edge the limit is reached wins: normal completion, rsp_err=0.
- **Undefined**
  - No counter; rsp_err is tied to 0 and the block waits indefinitely.

## Test plan
- Write 0x0000_0010 / 0xDEAD_BEEF against the team's responder -> awvalid/wvalid stable until handshake; rsp_valid 4 cycles after accept; rsp_err=0; rsp_rdata=0.
- Read back 0x0000_0010 -> rsp_rdata=0xDEAD_BEEF, 4-cycle latency, rready high only in RD_RESP.
- Stub responder with wready 3 cycles after awready -> awvalid drops after its handshake; wvalid held until its own; one bvalid completes the write.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable; cmd_ready=0 until the handshake.
- Assert reset while arvalid=1 -> all outputs 0 asynchronously; cmd_ready=1 the cycle after release; the next command completes normally.
- With AXIL_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, responder never asserts arready -> arvalid drops and rsp_valid=1 with rsp_err=1, rsp_rdata=0 after 16 cycles in RD_REQ.

Source files
------------

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator driven by a cmd/rsp request port.
// Define AXIL_MASTER_TIMEOUT_EN to add a watchdog that aborts stalled transactions with rsp_err.
module axi_lite_master #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP} state_t;
  state_t state;
  logic aw_done, w_done, aw_all, w_all;
  assign aw_all = aw_done | (awvalid & awready);
  assign w_all  = w_done | (wvalid & wready);
`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) > 9 ? $clog2(TIMEOUT_CYCLES + 1) : 9;
  logic [CW-1:0] cnt;
  logic busy, done_now, expired;
  always_comb begin
    busy     = state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
    done_now = state == WR_REQ ? aw_all & w_all : state == WR_RESP ? bvalid :
               state == RD_REQ ? arready : rvalid;
    expired  = busy && cnt == CW'(TIMEOUT_CYCLES - 1) && !done_now;
  end
`else
  assign rsp_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
      cnt       <= '0;
      rsp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              state   <= WR_REQ;
              awaddr  <= cmd_addr;
              wdata   <= cmd_wdata;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end else begin
              state   <= RD_REQ;
              araddr  <= cmd_addr;
              arvalid <= 1'b1;
            end
`ifdef AXIL_MASTER_TIMEOUT_EN
            cnt     <= '0;
            rsp_err <= 1'b0;
`endif
          end
        end
        WR_REQ: begin
          if (awvalid && awready) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (wvalid && wready) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_all && w_all) begin
            state  <= WR_RESP;
            bready <= 1'b1;
          end
        end
        WR_RESP: if (bvalid) begin
          state     <= RESP;
          bready    <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
        end
        RD_REQ: if (arready) begin
          state   <= RD_RESP;
          arvalid <= 1'b0;
          rready  <= 1'b1;
        end
        RD_RESP: if (rvalid) begin
          state     <= RESP;
          rready    <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= rdata;
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
`ifdef AXIL_MASTER_TIMEOUT_EN
      if (busy) cnt <= cnt + 1'b1;
      // watchdog overrides the case above; a same-edge handshake keeps done_now high and wins
      if (expired) begin
        state     <= RESP;
        awvalid   <= 1'b0;
        wvalid    <= 1'b0;
        arvalid   <= 1'b0;
        bready    <= 1'b0;
        rready    <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
`endif
    end
  end
endmodule
